// File: rtl/eth_tx_arb_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
package eth_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      ABORT = 2'd2,
      DRAIN = 2'd3
   } arb_state_t;

   localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first requester after 'last', wrapping
// modulo N_PORTS; returns the winner as one-hot and as an index.
module rr_pick #(
   parameter int unsigned N_PORTS = 2
) (
   input  logic [N_PORTS-1:0]         req,
   input  logic [$clog2(N_PORTS)-1:0] last,
   output logic [N_PORTS-1:0]         grant_oh,
   output logic [$clog2(N_PORTS)-1:0] grant_idx
);

   localparam int unsigned IDX_W = $clog2(N_PORTS);

   always_comb begin
      logic             found;
      logic [IDX_W-1:0] idx;
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int unsigned k = 1; k <= N_PORTS; k++) begin
         idx = IDX_W'((32'(last) + k) % N_PORTS);
         if (!found && req[idx]) begin
            found          = 1'b1;
            grant_oh[idx]  = 1'b1;
            grant_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one TX AXI-Stream slave between N_PORTS sources.
// Optional stall timeout with abort/drain is built when ETH_TX_ARB_TIMEOUT_EN is defined.
module eth_tx_arbiter
   import eth_tx_arb_pkg::*;
#(
   parameter int unsigned N_PORTS        = 2,
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [N_PORTS*DATA_W-1:0]    s_axis_tdata,
   input  logic [N_PORTS-1:0]           s_axis_tvalid,
   input  logic [N_PORTS-1:0]           s_axis_tlast,
   input  logic [N_PORTS-1:0]           s_axis_tuser,
   output logic [N_PORTS-1:0]           s_axis_tready,
   output logic [DATA_W-1:0]            m_axis_tdata,
   output logic                         m_axis_tvalid,
   output logic                         m_axis_tlast,
   output logic                         m_axis_tuser,
   input  logic                         m_axis_tready,
   output logic [$clog2(N_PORTS)-1:0]   grant_id,
   output logic                         busy,
   output logic [FRAME_CNT_W-1:0]       frame_count,
   output logic                         timeout_pulse
);

   localparam int unsigned IDX_W = $clog2(N_PORTS);

   if (N_PORTS < 2 || N_PORTS > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
      $error("eth_tx_arbiter: N_PORTS must be 2..8 and TIMEOUT_CYCLES nonzero");
   end

   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   busy_q;

   logic [N_PORTS-1:0]     pick_oh;
   logic [IDX_W-1:0]       pick_idx;

   logic [DATA_W-1:0]      g_data;
   logic                   g_valid;
   logic                   g_last;
   logic                   g_user;

`ifdef ETH_TX_ARB_TIMEOUT_EN
   localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [STALL_W-1:0]     stall_q, stall_d;
   logic                   pulse_q, pulse_d;
`endif

   rr_pick #(
      .N_PORTS (N_PORTS)
   ) u_rr_pick (
      .req       (s_axis_tvalid),
      .last      (last_q),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx)
   );

   // Granted source, selected by the registered grant
   assign g_data  = s_axis_tdata[grant_q*DATA_W +: DATA_W];
   assign g_valid = s_axis_tvalid[grant_q];
   assign g_last  = s_axis_tlast[grant_q];
   assign g_user  = s_axis_tuser[grant_q];

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      frame_cnt_d   = frame_cnt_q;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      s_axis_tready = '0;
`ifdef ETH_TX_ARB_TIMEOUT_EN
      stall_d       = stall_q;
      pulse_d       = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (|pick_oh) begin
               grant_d = pick_idx;
               state_d = XFER;
            end
         end
         XFER: begin
            m_axis_tdata           = g_data;
            m_axis_tvalid          = g_valid;
            m_axis_tlast           = g_last;
            m_axis_tuser           = g_user;
            s_axis_tready[grant_q] = m_axis_tready;
            if (g_valid && m_axis_tready) begin
`ifdef ETH_TX_ARB_TIMEOUT_EN
               stall_d = '0;
`endif
               if (g_last) begin
                  frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                  last_d      = grant_q;
                  state_d     = IDLE;
               end
            end
`ifdef ETH_TX_ARB_TIMEOUT_EN
            // Core is ready but the source has gone quiet: count toward abort
            else if (m_axis_tready) begin
               if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                  stall_d = '0;
                  state_d = ABORT;
               end else begin
                  stall_d = stall_q + STALL_W'(1);
               end
            end
`endif
         end
`ifdef ETH_TX_ARB_TIMEOUT_EN
         ABORT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tuser  = 1'b1;
            if (m_axis_tready) begin
               pulse_d = 1'b1;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            s_axis_tready[grant_q] = 1'b1;
            if (g_valid && g_last) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         last_q      <= IDX_W'(N_PORTS - 1);
         frame_cnt_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         frame_cnt_q <= frame_cnt_d;
         busy_q      <= (state_d != IDLE);
      end
   end

`ifdef ETH_TX_ARB_TIMEOUT_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         stall_q <= '0;
         pulse_q <= 1'b0;
      end else begin
         stall_q <= stall_d;
         pulse_q <= pulse_d;
      end
   end

   assign timeout_pulse = pulse_q;
`else
   assign timeout_pulse = 1'b0;
`endif

   assign grant_id    = grant_q;
   assign busy        = busy_q;
   assign frame_count = frame_cnt_q;

endmodule
